parking_bay_meter: RTL and testbench

Multi-bay parking meter core: tracks occupancy, paid time and violations for `NUM_BAYS` independent bays from one system clock, with an internal 1 Hz prescaler. It replaces the single-bay sensor/second-counter path. It sits between the debounced bay sensors and the payment inputs on one side, and the 7-segment display driver on the other. The bay chosen by `sel_bay` is presented as four BCD digits (mm:ss) plus an expired flag, which the display driver uses for blinking.

---
 rtl/parking_bay_meter.sv | 247 ++++++++++++++++++++++++
 tb/tb_parking_bay_meter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_bay_meter.sv
// Multi-bay parking meter core: per-bay occupancy/credit/violation tracking with a
// shared 1 Hz prescaler and a sequential mm:ss BCD converter for the selected bay.
module parking_bay_meter #(
  parameter int NUM_BAYS   = 4,
  parameter int TICK_DIV   = 100000000,
  parameter int SEC_W      = 13,
  parameter int MAX_SECS   = 5999,
  parameter int AMT_W      = 8,
  parameter int GRACE_SECS = 10,
  localparam int BAY_W     = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BAYS-1:0] parked,
  input  logic                add_valid,
  input  logic [BAY_W-1:0]    add_bay,
  input  logic [AMT_W-1:0]    add_amount,
  output logic                add_ack,
  input  logic [BAY_W-1:0]    sel_bay,
  output logic [NUM_BAYS-1:0] occupied,
  output logic [NUM_BAYS-1:0] paid,
  output logic [NUM_BAYS-1:0] expired,
  output logic [3:0]          digit3,
  output logic [3:0]          digit2,
  output logic [3:0]          digit1,
  output logic [3:0]          digit0,
  output logic                disp_expired,
  output logic                tick
);

  // state      | meaning
  // ST_VACANT  | no car in the bay
  // ST_GRACE   | car arrived, unpaid, grace seconds counting down
  // ST_PAID    | paid time remaining in rem
  // ST_EXPIRED | grace or paid time ran out while occupied
  // CV_LOAD    | latch selected bay rem/state, clear digit counters
  // CV_TMIN    | subtract 600 per cycle into digit3
  // CV_MIN     | subtract 60 per cycle into digit2
  // CV_TSEC    | subtract 10 per cycle into digit1
  // CV_DONE    | remainder is digit0, commit all digits
  typedef enum logic [1:0] {ST_VACANT, ST_GRACE, ST_PAID, ST_EXPIRED} bay_state_t;
  typedef enum logic [2:0] {CV_LOAD, CV_TMIN, CV_MIN, CV_TSEC, CV_DONE} cvt_state_t;

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SEC_W:0]   MAX_EXT   = (SEC_W+1)'(MAX_SECS);
  localparam logic [7:0]       GRACE_INI = 8'(GRACE_SECS);
  localparam logic [SEC_W-1:0] C600      = SEC_W'(600);
  localparam logic [SEC_W-1:0] C60       = SEC_W'(60);
  localparam logic [SEC_W-1:0] C10       = SEC_W'(10);

  logic [CNT_W-1:0] pre_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pre_cnt <= '0;
    else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
    else                        pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PRE_LAST);

  bay_state_t       st      [NUM_BAYS];
  bay_state_t       st_n    [NUM_BAYS];
  logic [SEC_W-1:0] rem     [NUM_BAYS];
  logic [SEC_W-1:0] rem_n   [NUM_BAYS];
  logic [SEC_W-1:0] rem_sat [NUM_BAYS];
  logic [7:0]       grace   [NUM_BAYS];
  logic [7:0]       grace_n [NUM_BAYS];
  logic [NUM_BAYS-1:0] credit;
  logic             bay_ok;
  logic             amt_nz;
  logic [SEC_W:0]   sum     [NUM_BAYS];

  assign bay_ok = ({1'b0, add_bay} < (BAY_W+1)'(NUM_BAYS));
  assign amt_nz = (add_amount != '0);

  // Credit qualification and saturating rem arithmetic, one wider bit so nothing wraps.
  always_comb begin
    for (int b = 0; b < NUM_BAYS; b++) begin
      credit[b] = add_valid && bay_ok && (add_bay == BAY_W'(b)) &&
                  (st[b] != ST_VACANT) && parked[b];
      sum[b] = {1'b0, rem[b]}
             - (SEC_W+1)'(tick && (st[b] == ST_PAID) && (rem[b] != '0))
             + (credit[b] ? (SEC_W+1)'(add_amount) : '0);
      rem_sat[b] = (sum[b] > MAX_EXT) ? MAX_EXT[SEC_W-1:0] : sum[b][SEC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BAYS; b++) begin
        st[b]    <= ST_VACANT;
        rem[b]   <= '0;
        grace[b] <= '0;
      end
      add_ack <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BAYS; b++) begin
        st[b]    <= st_n[b];
        rem[b]   <= rem_n[b];
        grace[b] <= grace_n[b];
      end
      add_ack <= |credit;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BAYS; b++) begin
      st_n[b]    = st[b];
      rem_n[b]   = rem[b];
      grace_n[b] = grace[b];
      if (!parked[b]) begin
        st_n[b]    = ST_VACANT;
        rem_n[b]   = '0;
        grace_n[b] = '0;
      end else begin
        case (st[b])
          ST_VACANT: begin
            st_n[b]    = ST_GRACE;
            grace_n[b] = GRACE_INI;
            rem_n[b]   = '0;
          end
          ST_GRACE: begin
            rem_n[b] = rem_sat[b];
            if (credit[b] && amt_nz) begin
              st_n[b] = ST_PAID;
            end else if (tick) begin
              grace_n[b] = grace[b] - 8'd1;
              if (grace[b] == 8'd1) st_n[b] = ST_EXPIRED;
            end
          end
          ST_PAID: begin
            rem_n[b] = rem_sat[b];
            if (rem_sat[b] == '0) st_n[b] = ST_EXPIRED;
          end
          default: begin
            rem_n[b] = rem_sat[b];
            if (credit[b] && amt_nz) st_n[b] = ST_PAID;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BAYS; b++) begin
      occupied[b] = (st[b] != ST_VACANT);
      paid[b]     = (st[b] == ST_PAID);
      expired[b]  = (st[b] == ST_EXPIRED);
    end
  end

  // Decoder-style select keeps an out-of-range sel_bay reading as zero.
  logic [SEC_W-1:0] rem_sel;
  logic             exp_sel;

  always_comb begin
    rem_sel = '0;
    exp_sel = 1'b0;
    for (int b = 0; b < NUM_BAYS; b++) begin
      if (sel_bay == BAY_W'(b)) begin
        rem_sel = rem[b];
        exp_sel = (st[b] == ST_EXPIRED);
      end
    end
  end

  // Empty digit stages are skipped so a full 5999 conversion takes 25 cycles.
  function automatic cvt_state_t stage_for(input logic [SEC_W-1:0] v);
    if (v >= C600)     return CV_TMIN;
    else if (v >= C60) return CV_MIN;
    else if (v >= C10) return CV_TSEC;
    else               return CV_DONE;
  endfunction

  cvt_state_t       cv_state, cv_state_n;
  logic [SEC_W-1:0] cv_val, cv_sub;
  logic [3:0]       cv_d3, cv_d2, cv_d1;
  logic             cv_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cv_state <= CV_LOAD;
    else     cv_state <= cv_state_n;
  end

  always_comb begin
    case (cv_state)
      CV_LOAD:                    cv_state_n = stage_for(rem_sel);
      CV_TMIN, CV_MIN, CV_TSEC:   cv_state_n = stage_for(cv_sub);
      default:                    cv_state_n = CV_LOAD;
    endcase
  end

  always_comb begin
    case (cv_state)
      CV_TMIN: cv_sub = cv_val - C600;
      CV_MIN:  cv_sub = cv_val - C60;
      CV_TSEC: cv_sub = cv_val - C10;
      default: cv_sub = cv_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv_val       <= '0;
      cv_exp       <= 1'b0;
      cv_d3        <= '0;
      cv_d2        <= '0;
      cv_d1        <= '0;
      digit3       <= '0;
      digit2       <= '0;
      digit1       <= '0;
      digit0       <= '0;
      disp_expired <= 1'b0;
    end else begin
      case (cv_state)
        CV_LOAD: begin
          cv_val <= rem_sel;
          cv_exp <= exp_sel;
          cv_d3  <= '0;
          cv_d2  <= '0;
          cv_d1  <= '0;
        end
        CV_TMIN: begin
          cv_val <= cv_sub;
          cv_d3  <= cv_d3 + 4'd1;
        end
        CV_MIN: begin
          cv_val <= cv_sub;
          cv_d2  <= cv_d2 + 4'd1;
        end
        CV_TSEC: begin
          cv_val <= cv_sub;
          cv_d1  <= cv_d1 + 4'd1;
        end
        default: begin
          digit3       <= cv_d3;
          digit2       <= cv_d2;
          digit1       <= cv_d1;
          digit0       <= cv_val[3:0];
          disp_expired <= cv_exp;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_bay_meter.sv
// Randomised and directed bench for parking_bay_meter against an integer-arithmetic
// reference model of the bay rules and a history window for the display path.
module tb_parking_bay_meter;
  localparam int NB = 4;
  localparam int TD = 128;
  localparam int GS = 3;
  localparam int SW = 13;
  localparam int MX = 5999;
  localparam int AW = 8;
  localparam int ST_VAC = 0, ST_GRC = 1, ST_PAY = 2, ST_EXP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] parked = '0;
  logic          add_valid = 1'b0;
  logic [1:0]    add_bay = '0;
  logic [AW-1:0] add_amount = '0;
  logic          add_ack;
  logic [1:0]    sel_bay = '0;
  logic [NB-1:0] occupied, paid, expired;
  logic [3:0]    digit3, digit2, digit1, digit0;
  logic          disp_expired, tick;

  parking_bay_meter #(
    .NUM_BAYS(NB), .TICK_DIV(TD), .SEC_W(SW), .MAX_SECS(MX), .AMT_W(AW), .GRACE_SECS(GS)
  ) dut (
    .clk(clk), .rst(rst), .parked(parked), .add_valid(add_valid), .add_bay(add_bay),
    .add_amount(add_amount), .add_ack(add_ack), .sel_bay(sel_bay), .occupied(occupied),
    .paid(paid), .expired(expired), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .digit0(digit0), .disp_expired(disp_expired), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_st [NB];
  int m_rem [NB];
  int m_grace [NB];
  int m_cnt;
  bit m_ack;
  int hist[$];
  logic [16:0] prev_disp = 'x;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int disp_val();
    return int'(digit3) * 600 + int'(digit2) * 60 + int'(digit1) * 10 + int'(digit0);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_st[b] = ST_VAC; m_rem[b] = 0; m_grace[b] = 0;
    end
    m_cnt = 0;
    m_ack = 1'b0;
    hist.delete();
    hist.push_back(0);
  endtask

  task automatic model_step(input logic [NB-1:0] p, input bit av, input int ab, input int amt);
    bit tk;
    bit acc;
    int r;
    tk    = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    m_ack = 1'b0;
    for (int b = 0; b < NB; b++) begin
      acc = av && (ab == b) && (m_st[b] != ST_VAC) && p[b];
      if (!p[b]) begin
        m_st[b] = ST_VAC; m_rem[b] = 0; m_grace[b] = 0;
      end else if (m_st[b] == ST_VAC) begin
        m_st[b] = ST_GRC; m_grace[b] = GS; m_rem[b] = 0;
      end else begin
        if (acc) m_ack = 1'b1;
        r = m_rem[b];
        if (tk && m_st[b] == ST_PAY && r > 0) r = r - 1;
        if (acc) r = (r + amt > MX) ? MX : r + amt;
        m_rem[b] = r;
        if (acc && amt > 0 && m_st[b] != ST_PAY) begin
          m_st[b] = ST_PAY;
        end else if (m_st[b] == ST_GRC && tk) begin
          m_grace[b] = m_grace[b] - 1;
          if (m_grace[b] == 0) m_st[b] = ST_EXP;
        end else if (m_st[b] == ST_PAY && r == 0) begin
          m_st[b] = ST_EXP;
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [NB-1:0] e_occ, e_paid, e_exp;
    logic [16:0] cur;
    int v, found;
    for (int b = 0; b < NB; b++) begin
      e_occ[b]  = (m_st[b] != ST_VAC);
      e_paid[b] = (m_st[b] == ST_PAY);
      e_exp[b]  = (m_st[b] == ST_EXP);
    end
    chk("occupied", occupied, e_occ);
    chk("paid", paid, e_paid);
    chk("expired", expired, e_exp);
    chk("add_ack", add_ack, m_ack);
    chk("tick", tick, (m_cnt == TD - 1));
    cur = {digit3, digit2, digit1, digit0, disp_expired};
    if (cur !== prev_disp) begin
      prev_disp = cur;
      v = disp_val() * 2 + int'(disp_expired);
      found = hist[hist.size() - 1];
      foreach (hist[i]) if (hist[i] == v) found = v;
      chk("disp_in_window", v, found);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(parked, add_valid, int'(add_bay), int'(add_amount));
      #1;
      check_cycle();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      hist.push_back(m_rem[int'(sel_bay)] * 2 + int'(m_st[int'(sel_bay)] == ST_EXP));
      if (hist.size() > 64) void'(hist.pop_front());
    end
  end

  task automatic credit(input int bay, input int amt);
    add_valid  = 1'b1;
    add_bay    = 2'(bay);
    add_amount = AW'(amt);
    @(negedge clk);
    add_valid  = 1'b0;
  endtask

  task automatic wait_tick_high();
    int n = 0;
    while (tick !== 1'b1 && n < TD + 4) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", tick, 1'b1);
  endtask

  task automatic first_tick(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < TD + 4);
    chk(tag, n + 1, TD);
  endtask

  task automatic wait_disp(input string tag, input int val, input bit ex);
    int n = 0;
    while (!(disp_val() == val && disp_expired === ex) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, disp_val() * 2 + int'(disp_expired), val * 2 + int'(ex));
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_flags", {occupied, paid, expired}, '0);
    chk("rst_digits", {digit3, digit2, digit1, digit0, disp_expired}, '0);
    chk("rst_ack_tick", {add_ack, tick}, '0);
    rst = 1'b0;
    first_tick("first_tick_cycles");

    // grace countdown to expiry on bay 0
    parked[0] = 1'b1;
    sel_bay   = 2'd0;
    @(negedge clk);
    chk("grace_occupied", occupied[0], 1'b1);
    n = 1;
    while (expired[0] !== 1'b1 && n < 4 * TD + 8) begin
      @(negedge clk);
      n++;
    end
    chk("grace_expired", expired[0], 1'b1);
    chk("grace_cycles", n, 3 * TD + 1);
    wait_disp("disp_expired_bay0", 0, 1'b1);

    // credit 125 s on bay 1, then one tick
    wait_tick_high();
    @(negedge clk);
    parked[1] = 1'b1;
    @(negedge clk);
    credit(1, 125);
    chk("ack_125", add_ack, 1'b1);
    chk("paid_bay1", paid[1], 1'b1);
    sel_bay = 2'd1;
    wait_disp("disp_125", 125, 1'b0);
    chk("digits_125", {digit3, digit2, digit1, digit0}, 16'h0205);
    wait_tick_high();
    @(negedge clk);
    wait_disp("disp_124", 124, 1'b0);
    chk("digits_124", {digit3, digit2, digit1, digit0}, 16'h0204);

    // saturation: bay 2 reaches 5990 then +200
    wait_tick_high();
    @(negedge clk);
    parked[2] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 23; i++) credit(2, 255);
    credit(2, 125);
    credit(2, 200);
    chk("ack_sat", add_ack, 1'b1);
    sel_bay = 2'd2;
    wait_disp("disp_sat", MX, 1'b0);
    chk("digits_sat", {digit3, digit2, digit1, digit0}, 16'h9959);

    // credit and tick in the same cycle on bay 3
    wait_tick_high();
    @(negedge clk);
    parked[3] = 1'b1;
    @(negedge clk);
    credit(3, 10);
    wait_tick_high();
    credit(3, 5);
    chk("ack_tick_credit", add_ack, 1'b1);
    sel_bay = 2'd3;
    wait_disp("disp_14", 14, 1'b0);

    // vacant bay credit and same-cycle departure
    parked[0] = 1'b0;
    @(negedge clk);
    chk("vacated_bay0", occupied[0], 1'b0);
    parked[0] = 1'b1;
    credit(0, 50);
    chk("ack_vacant", add_ack, 1'b0);
    chk("vacant_to_grace", {occupied[0], paid[0]}, 2'b10);
    parked[2] = 1'b0;
    credit(2, 50);
    chk("ack_depart", add_ack, 1'b0);
    chk("depart_vacant", occupied[2], 1'b0);
    sel_bay = 2'd2;
    wait_disp("disp_depart", 0, 1'b0);

    // asynchronous reset while bay 3 is paid
    credit(3, 255);
    credit(3, 31);
    chk("bay3_paid", paid[3], 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_flags", {occupied, paid, expired}, '0);
    chk("arst_digits", {digit3, digit2, digit1, digit0, disp_expired}, '0);
    chk("arst_ack_tick", {add_ack, tick}, '0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_tick("first_tick_after_arst");

    // randomised traffic
    parked = '1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 63) == 0) parked[b] = ~parked[b];
      add_valid  = ($urandom_range(0, 15) == 0);
      add_bay    = 2'($urandom_range(0, NB - 1));
      add_amount = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) sel_bay = 2'($urandom_range(0, NB - 1));
      @(negedge clk);
    end
    add_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
